// File: rtl/scan_plain_serializer.sv
// Bit-serial scan-in feeder for decrypted plaintext blocks: a holding register plus a
// shift register give gap-free streaming, and a running CRC-16 covers every emitted bit.
module scan_plain_serializer #(
  parameter int          BLOCK_W  = 128,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pt_valid,
  input  logic [BLOCK_W-1:0] plaintext,
  output logic               pt_ready,
  input  logic               shift_en,
  output logic               si_out,
  output logic               si_valid,
  output logic               blk_last,
  input  logic               crc_clr,
  output logic [15:0]        crc_out,
  output logic               busy
);

  localparam int CNT_W = $clog2(BLOCK_W);

  logic [BLOCK_W-1:0] sr;
  logic [BLOCK_W-1:0] hr;
  logic               sr_full;
  logic               hr_full;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        crc;

  logic accept;
  logic step;
  logic last_step;

  // CCITT CRC-16, one bit per call, MSB-first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign pt_ready  = !hr_full;
  assign busy      = sr_full | hr_full;
  assign crc_out   = crc;
  assign accept    = pt_valid && pt_ready;
  assign step      = sr_full && shift_en;
  assign last_step = step && (cnt == CNT_W'(BLOCK_W - 1));

  // Block storage: SR refills from HR first, else straight from the input on the final bit.
  always_ff @(posedge clk) begin
    if (last_step && hr_full)
      sr <= hr;
    else if (accept && (!sr_full || last_step))
      sr <= plaintext;
    else if (step)
      sr <= sr << 1;

    if (accept && sr_full && !last_step)
      hr <= plaintext;
  end

  // Control, serial output and CRC.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_full  <= 1'b0;
      hr_full  <= 1'b0;
      cnt      <= '0;
      si_out   <= 1'b0;
      si_valid <= 1'b0;
      blk_last <= 1'b0;
      crc      <= CRC_INIT;
    end else begin
      si_valid <= step;
      blk_last <= last_step;

      if (step) begin
        si_out <= sr[BLOCK_W-1];
        cnt    <= last_step ? '0 : cnt + 1'b1;
        // A clear coinciding with a bit reseeds first, then folds that bit in.
        crc    <= crc_step(crc_clr ? CRC_INIT : crc, sr[BLOCK_W-1]);
      end else if (crc_clr) begin
        crc <= CRC_INIT;
      end

      if (last_step)
        sr_full <= hr_full || accept;
      else if (accept && !sr_full)
        sr_full <= 1'b1;

      if (last_step && hr_full)
        hr_full <= 1'b0;
      else if (accept && sr_full && !last_step)
        hr_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_plain_serializer.sv
// Scoreboard bench for scan_plain_serializer: accepted blocks queue their expected bits,
// and a negedge monitor checks the serial stream and a reference CRC.
module tb_scan_plain_serializer;

  localparam int BLOCK_W = 128;

  logic               clk = 1'b0;
  logic               reset;
  logic               pt_valid;
  logic [BLOCK_W-1:0] plaintext;
  logic               pt_ready;
  logic               shift_en;
  logic               si_out;
  logic               si_valid;
  logic               blk_last;
  logic               crc_clr;
  logic [15:0]        crc_out;
  logic               busy;

  scan_plain_serializer #(.BLOCK_W(BLOCK_W), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .pt_valid(pt_valid), .plaintext(plaintext),
    .pt_ready(pt_ready), .shift_en(shift_en), .si_out(si_out), .si_valid(si_valid),
    .blk_last(blk_last), .crc_clr(crc_clr), .crc_out(crc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   bits_out = 0;
  int   run = 0;
  int   max_run = 0;

  function automatic logic [15:0] ref_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] ref_crc64(input logic [63:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 63; i >= 0; i--) c = ref_step(c, d[i]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: control inputs are sampled one negedge ahead so they line up with the edge they hit.
  logic        rst_q = 1'b1;
  logic        clr_q = 1'b0;
  logic [15:0] model = 16'hFFFF;
  logic        last_si = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      q.delete();
      model   = 16'hFFFF;
      last_si = 1'b0;
      run     = 0;
    end else begin
      if (si_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", 128'(si_valid), 128'(0));
        end else begin
          e = q.pop_front();
          chk("si_out", 128'(si_out), 128'(e.b));
          chk("blk_last", 128'(blk_last), 128'(e.last));
          model = ref_step(clr_q ? 16'hFFFF : model, e.b);
        end
        last_si = si_out;
        bits_out++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        chk("si_out_hold", 128'(si_out), 128'(last_si));
        chk("blk_last_idle", 128'(blk_last), 128'(0));
        if (clr_q) model = 16'hFFFF;
        run = 0;
      end
      chk("crc_out", 128'(crc_out), 128'(model));
    end
    rst_q = reset;
    clr_q = crc_clr;
  end

  task automatic send(input logic [BLOCK_W-1:0] blk, output int waited);
    exp_t e;
    bit   ok;
    waited    = 0;
    ok        = 1'b0;
    pt_valid  = 1'b1;
    plaintext = blk;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (pt_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    for (int i = BLOCK_W - 1; i >= 0; i--) begin
      e.b    = blk[i];
      e.last = (i == 0);
      q.push_back(e);
    end
    @(posedge clk); #1;
    pt_valid = 1'b0;
  endtask

  task automatic wait_bits(input int target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (bits_out >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bits_timeout", 128'(bits_out), 128'(target));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 128'(q.size()), 128'(0));
  endtask

  initial begin
    int w;
    int start;
    logic [BLOCK_W-1:0] blk;
    reset = 1'b1; pt_valid = 1'b0; plaintext = '0; shift_en = 1'b1; crc_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_si_out", 128'(si_out), 128'(0));
    chk("rst_si_valid", 128'(si_valid), 128'(0));
    chk("rst_blk_last", 128'(blk_last), 128'(0));
    chk("rst_crc", 128'(crc_out), 128'(16'hFFFF));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pt_ready", 128'(pt_ready), 128'(1));
    @(posedge clk); #1;

    // Single MSB-set block: first bit one cycle after accept.
    send(128'h80000000_00000000_00000000_00000000, w);
    @(negedge clk); @(negedge clk);
    chk("t1_first_valid", 128'(si_valid), 128'(1));
    chk("t1_first_bit", 128'(si_out), 128'(1));
    chk("t1_crc_first", 128'(crc_out), 128'(16'hFFFE));
    drain();

    // All-zero block after reseeding.
    crc_clr = 1'b1; @(posedge clk); #1; crc_clr = 1'b0;
    send('0, w);
    @(negedge clk); @(negedge clk);
    chk("t2_crc_first", 128'(crc_out), 128'(16'hEFDF));
    drain();

    // Three blocks back to back.
    max_run = 0;
    blk = 128'h0123456789abcdef0123456789abcdef;
    send(blk, w);
    chk("t3_wait_a", 128'(w), 128'(0));
    send(~blk, w);
    chk("t3_wait_b", 128'(w), 128'(0));
    send('1, w);
    chk("t3_ready_low_cycles", 128'(w), 128'(127));
    drain();
    chk("t3_contiguous", 128'(max_run), 128'(384));

    // Stall for 7 cycles after bit 50.
    start = bits_out;
    send(128'h0123456789abcdef_fedcba9876543210, w);
    wait_bits(start + 51);
    shift_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", 128'(si_valid), 128'(0));
    end
    shift_en = 1'b1;
    drain();
    chk("t4_bit_count", 128'(bits_out - start), 128'(128));

    // Reseed on the edge that emits bit 64.
    start = bits_out;
    blk = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    send(blk, w);
    wait_bits(start + 63);
    crc_clr = 1'b1; @(posedge clk); #1; crc_clr = 1'b0;
    drain();
    chk("t5_crc_tail", 128'(crc_out), 128'(ref_crc64(blk[63:0])));

    // Reset mid-block with the holding register occupied.
    start = bits_out;
    send(128'h11112222_33334444_55556666_77778888, w);
    send(128'h99990000_aaaabbbb_ccccdddd_eeeeffff, w);
    wait_bits(start + 90);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_pt_ready", 128'(pt_ready), 128'(1));
    chk("t6_si_valid", 128'(si_valid), 128'(0));
    chk("t6_crc", 128'(crc_out), 128'(16'hFFFF));
    @(posedge clk); #1;
    send(128'hc0ffee00_12345678_87654321_00000001, w);
    @(negedge clk); @(negedge clk);
    chk("t6_first_bit", 128'(si_out), 128'(1));
    chk("t6_crc_first", 128'(crc_out), 128'(16'hFFFE));
    drain();
    chk("queue_empty", 128'(q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_plain_serializer.md
Name: scan_plain_serializer

Overview:
- Sits directly downstream of the decrypt core. Takes each 128-bit plaintext block it produces and shifts it bit-serially into the die's scan-in path, under the 1838 scan controller's shift enable.
- Provides two-deep buffering (holding register plus shift register) so consecutive decrypted blocks stream with no gap.
- Maintains a running CRC-16 over every emitted bit for scan integrity checking.

Parameters:
- BLOCK_W, 128, plaintext block width in bits; bit counter is clog2(BLOCK_W) bits wide.
- CRC_INIT, 16'hFFFF, CRC seed value loaded on reset and on crc_clr.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pt_valid  in  1  plaintext block available from the decrypt core.
- plaintext  in  BLOCK_W  decrypted block; sampled only when pt_valid && pt_ready.
- pt_ready  out  1  block can be accepted this cycle.
- shift_en  in  1  scan shift enable from the scan controller; low stalls shifting.
- si_out  out  1  registered serial scan-in bit.
- si_valid  out  1  si_out carries a new bit this cycle.
- blk_last  out  1  high with the final (BLOCK_W-th) bit of a block.
- crc_clr  in  1  reseed the CRC.
- crc_out  out  16  running CRC-16 over emitted bits.
- busy  out  1  at least one block is buffered or shifting.

Behaviour:
- Reset: si_out=0, si_valid=0, blk_last=0, crc_out=CRC_INIT, busy=0, pt_ready=1. Both buffers are invalidated and the counter is cleared. Reset mid-block discards buffered and partially shifted data; no further bits are emitted.
- Storage: shift register SR with sr_full flag; holding register HR with hr_full flag; bit counter cnt.
- pt_ready = !hr_full (combinational).
- Accept (pt_valid && pt_ready):
  - Block goes to SR if SR is empty, or if SR emits its last bit this edge and HR is empty.
  - Otherwise the block goes to HR.
- Shift step (sr_full && shift_en): on the edge, si_out<=SR[BLOCK_W-1], SR<=SR<<1, si_valid<=1, cnt<=cnt+1. Bits go out MSB first.
- No shift step: si_valid<=0, blk_last<=0, si_out holds its value.
- Block end: blk_last<=1 on the step where cnt==BLOCK_W-1. On that same edge:
  - cnt wraps to 0.
  - If hr_full, HR moves into SR and hr_full clears.
  - Else an accepted block loads SR directly.
  - Else sr_full clears.
  - Result: back-to-back blocks emit with zero idle cycles while shift_en stays high.
- Latency: block accepted into empty SR at edge N, with shift_en high → first bit valid in cycle N+1, last bit (blk_last) in cycle N+BLOCK_W.
- Buffer full: sr_full && hr_full → pt_ready=0. Upstream must hold pt_valid and plaintext stable until accepted.
- CRC (CCITT, poly 0x1021, MSB-first): per emitted bit b, fb=crc[15]^b; crc={crc[14:0],0}^(fb?16'h1021:0).
- crc_clr: with no emitted bit, crc<=CRC_INIT. With an emitted bit on the same edge, crc<=update(CRC_INIT,b); the clear applies first and the bit is included.
- shift_en dropped mid-block: state is frozen (cnt, SR, CRC); resumes exactly at the next bit. Accepts into HR continue while stalled.
- busy = sr_full | hr_full.

Test Plan:
- Reset, then pt_valid with plaintext=128'h80000000_00000000_00000000_00000000, shift_en=1 → si_valid high cycles 1..128; si_out=1 in cycle 1, 0 after; blk_last only in cycle 128; crc_out=16'hFFFE after first bit.
- Same flow with plaintext=0 → after first bit, crc_out=16'hEFDF. After 128 bits, crc_out matches the bench reference model.
- Three blocks offered back-to-back (0x0123456789abcdef0123456789abcdef, its inverse, all ones), shift_en=1 → 384 contiguous si_valid cycles; pt_ready low while both buffers full; bit stream equals the concatenation, MSB first.
- Toggle shift_en low for 7 cycles at bit 50 → si_valid low, si_out held; resumed stream bit-exact; blk_last at the 128th valid bit.
- Assert crc_clr on the edge of bit 64 → crc_out equals the CRC of bits 64..127 seeded with 16'hFFFF.
- Assert reset at bit 90 with HR full → next cycle busy=0, pt_ready=1, si_valid=0, crc_out=16'hFFFF; a new block then starts from its bit 127.
